multicycle_control_unit: RTL and testbench

//  Multi-cycle FSM controller for the processor datapath. Sequences FETCH/DECODE/EXEC/MEM/WB per

---
 rtl/multicycle_control_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle FSM controller for the processor datapath. Each instruction walks
// through FETCH / DECODE / EXEC / MEM / WB as needed. The controller drives the
// datapath mux selects, the register and memory enables and the ALU opcode.
// Memory accesses stall on a ready handshake. If memory stays silent for too
// long, the FSM drops into a TRAP state that only reset can clear. Unknown
// opcodes raise a one-cycle illegal_op flag.
//
// Parameters
//   OPCODE_W     opcode width (encodings zero-extended to this width)
//   ALU_OP_W     ALU opcode / funct width
//   MEM_TIMEOUT  max wait cycles with mem_ready low before trap, 0 disables
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   i_opcode        instruction opcode from IR, sampled in DECODE
//   i_funct         R-type function field, sampled in DECODE
//   i_zero          ALU zero flag, used in EXEC for BEQ
//   i_mem_ready     memory completes the access this cycle
//   o_pc_src        00 PC+4, 01 branch target, 10 jump target
//   o_pc_enable     PC load
//   o_ir_write      IR load
//   o_reg_src       writeback data: 0 ALU, 1 memory
//   o_reg_dst       dest reg: 0 rt, 1 rd
//   o_alu_src1      ALU A: 0 PC, 1 rs
//   o_alu_src2      ALU B: 0 rt, 1 sign-extended immediate
//   o_reg_write     register file write enable
//   o_mem_word      1 word access, 0 byte access
//   o_mem_read      memory read request
//   o_mem_write     memory write request
//   o_alu_opcode    ALU operation
//   o_illegal_op    one-cycle pulse in DECODE for an unknown opcode
//   o_bus_error     high while in TRAP
//   o_state         current state (INIT 0 .. TRAP 6)
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OPCODE_W    = 6,
    parameter int ALU_OP_W    = 6,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [ALU_OP_W-1:0] i_funct,
    input  logic                i_zero,
    input  logic                i_mem_ready,
    output logic [1:0]          o_pc_src,
    output logic                o_pc_enable,
    output logic                o_ir_write,
    output logic                o_reg_src,
    output logic                o_reg_dst,
    output logic                o_alu_src1,
    output logic                o_alu_src2,
    output logic                o_reg_write,
    output logic                o_mem_word,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic [ALU_OP_W-1:0] o_alu_opcode,
    output logic                o_illegal_op,
    output logic                o_bus_error,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_LB   = OPCODE_W'(6'b100000);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_SB   = OPCODE_W'(6'b101000);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(6'b100000);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(6'b100010);

    // The counter only ever needs to hold MEM_TIMEOUT-1.
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TERM_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_TERM = TERM_I[CNT_W-1:0];
    localparam bit TMO_EN = (MEM_TIMEOUT > 0);

    state_t                r_state;
    state_t                w_next_state;
    logic [OPCODE_W-1:0]   r_op;
    logic [ALU_OP_W-1:0]   r_funct;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_next_cnt;
    logic [OPCODE_W-1:0]   w_dec_op;
    logic                  w_timeout;
    logic                  w_is_load;
    logic                  w_is_word;

    // DECODE has to act on the opcode in the same cycle it is latched, so it
    // looks at the live IR field; every later state uses the latched copy.
    assign w_dec_op  = (r_state == S_DECODE) ? i_opcode : r_op;
    assign w_is_load = (r_op == OP_LW) || (r_op == OP_LB);
    assign w_is_word = (r_op == OP_LW) || (r_op == OP_SW);

    // Ready wins over a terminal count arriving in the same cycle.
    assign w_timeout = TMO_EN && (r_cnt == CNT_TERM) && !i_mem_ready;

    assign o_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_op    <= '0;
            r_funct <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (r_state == S_DECODE) begin
                r_op    <= i_opcode;
                r_funct <= i_funct;
            end
        end
    end

    // Stall counter: runs only while waiting on memory in the same state.
    always_comb begin
        w_next_cnt = '0;
        if ((w_next_state == r_state) && !i_mem_ready &&
            ((r_state == S_FETCH) || (r_state == S_MEM))) begin
            w_next_cnt = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_pc_src     = 2'b00;
        o_pc_enable  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_src    = 1'b0;
        o_reg_dst    = 1'b0;
        o_alu_src1   = 1'b0;
        o_alu_src2   = 1'b0;
        o_reg_write  = 1'b0;
        o_mem_word   = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_alu_opcode = '0;
        o_illegal_op = 1'b0;
        o_bus_error  = 1'b0;

        case (r_state)
            S_INIT: begin
                w_next_state = S_FETCH;
            end

            S_FETCH: begin
                o_mem_read = 1'b1;
                o_mem_word = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write   = 1'b1;
                    o_pc_enable  = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                end
            end

            S_DECODE: begin
                case (w_dec_op)
                    OP_J: begin
                        o_pc_enable  = 1'b1;
                        o_pc_src     = 2'b10;
                        w_next_state = S_FETCH;
                    end
                    OP_R, OP_ADDI, OP_LW, OP_LB, OP_SW, OP_SB, OP_BEQ: begin
                        w_next_state = S_EXEC;
                    end
                    default: begin
                        o_illegal_op = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end

            S_EXEC: begin
                o_alu_src1 = 1'b1;
                case (r_op)
                    OP_R: begin
                        o_alu_opcode = r_funct;
                        w_next_state = S_WB;
                    end
                    OP_ADDI: begin
                        o_alu_opcode = ALU_ADD;
                        o_alu_src2   = 1'b1;
                        w_next_state = S_WB;
                    end
                    OP_LW, OP_LB, OP_SW, OP_SB: begin
                        o_alu_opcode = ALU_ADD;
                        o_alu_src2   = 1'b1;
                        w_next_state = S_MEM;
                    end
                    OP_BEQ: begin
                        o_alu_opcode = ALU_SUB;
                        o_pc_src     = 2'b01;
                        o_pc_enable  = i_zero;
                        w_next_state = S_FETCH;
                    end
                    default: begin
                        w_next_state = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                o_mem_word  = w_is_word;
                o_mem_read  = w_is_load;
                o_mem_write = !w_is_load;
                if (i_mem_ready) begin
                    w_next_state = w_is_load ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                end
            end

            S_WB: begin
                o_reg_write  = 1'b1;
                o_reg_src    = w_is_load;
                o_reg_dst    = (r_op == OP_R);
                w_next_state = S_FETCH;
            end

            S_TRAP: begin
                o_bus_error  = 1'b1;
            end

            default: begin
                w_next_state = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench for the multicycle controller. Each step drives inputs just
// after a rising edge, queues the full expected output snapshot, and pops it
// for comparison on the following falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [2:0] state;
        logic [1:0] pcSrc;
        logic       pcEnable;
        logic       irWrite;
        logic       regSrc;
        logic       regDst;
        logic       aluSrc1;
        logic       aluSrc2;
        logic       regWrite;
        logic       memWord;
        logic       memRead;
        logic       memWrite;
        logic [5:0] aluOp;
        logic       illegalOp;
        logic       busError;
    } outs_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;
    logic [1:0] pcSrc;
    logic       pcEnable, irWrite, regSrc, regDst, aluSrc1, aluSrc2;
    logic       regWrite, memWord, memRead, memWrite, illegalOp, busError;
    logic [5:0] aluOpcode;
    logic [2:0] state;
    outs_t      observed;

    int checks = 0;
    int failures = 0;

    string tagQ[$];
    outs_t expQ[$];

    multicycle_control_unit #(
        .OPCODE_W   (6),
        .ALU_OP_W   (6),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_opcode    (opcode),
        .i_funct     (funct),
        .i_zero      (zero),
        .i_mem_ready (memReady),
        .o_pc_src    (pcSrc),
        .o_pc_enable (pcEnable),
        .o_ir_write  (irWrite),
        .o_reg_src   (regSrc),
        .o_reg_dst   (regDst),
        .o_alu_src1  (aluSrc1),
        .o_alu_src2  (aluSrc2),
        .o_reg_write (regWrite),
        .o_mem_word  (memWord),
        .o_mem_read  (memRead),
        .o_mem_write (memWrite),
        .o_alu_opcode(aluOpcode),
        .o_illegal_op(illegalOp),
        .o_bus_error (busError),
        .o_state     (state)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    assign observed = '{state, pcSrc, pcEnable, irWrite, regSrc, regDst,
                        aluSrc1, aluSrc2, regWrite, memWord, memRead,
                        memWrite, aluOpcode, illegalOp, busError};

    // Expected snapshots, one builder per controller state.
    function automatic outs_t sInit();
        outs_t e = '0;
        return e;
    endfunction

    function automatic outs_t sFetch(input logic rdy);
        outs_t e = '0;
        e.state = 3'd1; e.memRead = 1'b1; e.memWord = 1'b1;
        e.irWrite = rdy; e.pcEnable = rdy;
        return e;
    endfunction

    function automatic outs_t sDecode(input logic jump, input logic bad);
        outs_t e = '0;
        e.state = 3'd2; e.illegalOp = bad;
        e.pcEnable = jump; e.pcSrc = jump ? 2'b10 : 2'b00;
        return e;
    endfunction

    function automatic outs_t sExec(input logic [5:0] alu, input logic src2,
                                    input logic [1:0] psrc, input logic pen);
        outs_t e = '0;
        e.state = 3'd3; e.aluSrc1 = 1'b1; e.aluOp = alu; e.aluSrc2 = src2;
        e.pcSrc = psrc; e.pcEnable = pen;
        return e;
    endfunction

    function automatic outs_t sMem(input logic word, input logic rd, input logic wr);
        outs_t e = '0;
        e.state = 3'd4; e.memWord = word; e.memRead = rd; e.memWrite = wr;
        return e;
    endfunction

    function automatic outs_t sWb(input logic rsrc, input logic rdst);
        outs_t e = '0;
        e.state = 3'd5; e.regWrite = 1'b1; e.regSrc = rsrc; e.regDst = rdst;
        return e;
    endfunction

    function automatic outs_t sTrap();
        outs_t e = '0;
        e.state = 3'd6; e.busError = 1'b1;
        return e;
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy);
        opcode   = op;
        funct    = fn;
        zero     = z;
        memReady = rdy;
    endtask

    task automatic checkOutput();
        string tag;
        outs_t exp;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard-empty observed=%h required=<entry>", observed);
        end else begin
            tag = tagQ.pop_front();
            exp = expQ.pop_front();
            assert (observed === exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h (state %0d) required=%h (state %0d)",
                       tag, observed, observed.state, exp, exp.state);
            end
        end
    endtask

    // One clock cycle: queue expectation, check at the falling edge, advance.
    task automatic step(input string tag, input outs_t e);
        tagQ.push_back(tag);
        expQ.push_back(e);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous check mid-cycle, without waiting for an edge.
    task automatic stepNow(input string tag, input outs_t e);
        tagQ.push_back(tag);
        expQ.push_back(e);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(OP_R, 6'b100100, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        step("reset-init", sInit());

        // R-type, zero wait: 0,1,2,3,5,1
        rst_n = 1'b1;
        step("r-init", sInit());
        step("r-fetch", sFetch(1'b1));
        step("r-decode", sDecode(1'b0, 1'b0));
        applyStimulus(OP_J, 6'b000000, 1'b0, 1'b1);
        step("r-exec", sExec(6'b100100, 1'b0, 2'b00, 1'b0));
        step("r-wb", sWb(1'b0, 1'b1));

        // LW with 3 wait cycles in MEM; ready on the terminal count completes
        applyStimulus(OP_LW, 6'b000000, 1'b0, 1'b1);
        step("lw-fetch", sFetch(1'b1));
        step("lw-decode", sDecode(1'b0, 1'b0));
        memReady = 1'b0;
        step("lw-exec", sExec(ALU_ADD, 1'b1, 2'b00, 1'b0));
        step("lw-mem-wait1", sMem(1'b1, 1'b1, 1'b0));
        step("lw-mem-wait2", sMem(1'b1, 1'b1, 1'b0));
        step("lw-mem-wait3", sMem(1'b1, 1'b1, 1'b0));
        memReady = 1'b1;
        step("lw-mem-ready", sMem(1'b1, 1'b1, 1'b0));
        step("lw-wb", sWb(1'b1, 1'b0));

        // BEQ taken then not taken; opcode change after DECODE is ignored
        applyStimulus(OP_BEQ, 6'b000000, 1'b1, 1'b1);
        step("beq1-fetch", sFetch(1'b1));
        step("beq1-decode", sDecode(1'b0, 1'b0));
        opcode = OP_J;
        step("beq1-exec-taken", sExec(ALU_SUB, 1'b0, 2'b01, 1'b1));
        applyStimulus(OP_BEQ, 6'b000000, 1'b0, 1'b1);
        step("beq0-fetch", sFetch(1'b1));
        step("beq0-decode", sDecode(1'b0, 1'b0));
        step("beq0-exec-nottaken", sExec(ALU_SUB, 1'b0, 2'b01, 1'b0));

        // SB: byte store
        applyStimulus(OP_SB, 6'b000000, 1'b0, 1'b1);
        step("sb-fetch", sFetch(1'b1));
        step("sb-decode", sDecode(1'b0, 1'b0));
        step("sb-exec", sExec(ALU_ADD, 1'b1, 2'b00, 1'b0));
        step("sb-mem", sMem(1'b0, 1'b0, 1'b1));

        // J and ADDI
        applyStimulus(OP_J, 6'b000000, 1'b0, 1'b1);
        step("j-fetch", sFetch(1'b1));
        step("j-decode", sDecode(1'b1, 1'b0));
        applyStimulus(OP_ADDI, 6'b000000, 1'b0, 1'b1);
        step("addi-fetch", sFetch(1'b1));
        step("addi-decode", sDecode(1'b0, 1'b0));
        step("addi-exec", sExec(ALU_ADD, 1'b1, 2'b00, 1'b0));
        step("addi-wb", sWb(1'b0, 1'b0));

        // Illegal opcode: single-cycle pulse, back to FETCH
        applyStimulus(OP_BAD, 6'b000000, 1'b0, 1'b1);
        step("bad-fetch", sFetch(1'b1));
        step("bad-decode", sDecode(1'b0, 1'b1));
        applyStimulus(OP_J, 6'b000000, 1'b0, 1'b0);
        step("bad-next-fetch", sFetch(1'b0));

        // Ready arrives on the 4th waiting FETCH cycle: no trap
        step("fetch-wait2", sFetch(1'b0));
        step("fetch-wait3", sFetch(1'b0));
        memReady = 1'b1;
        step("fetch-ready4", sFetch(1'b1));
        memReady = 1'b0;
        step("fetch-late-decode", sDecode(1'b1, 1'b0));

        // Four silent FETCH cycles trap; TRAP holds even with ready
        step("trap-fetch1", sFetch(1'b0));
        step("trap-fetch2", sFetch(1'b0));
        step("trap-fetch3", sFetch(1'b0));
        step("trap-fetch4", sFetch(1'b0));
        step("trap-hold1", sTrap());
        memReady = 1'b1;
        step("trap-hold2", sTrap());
        rst_n = 1'b0;
        stepNow("trap-reset-async", sInit());
        @(posedge clk);
        #1;

        // Reset in the middle of an SW memory wait
        rst_n = 1'b1;
        applyStimulus(OP_SW, 6'b000000, 1'b0, 1'b1);
        step("sw-init", sInit());
        step("sw-fetch", sFetch(1'b1));
        step("sw-decode", sDecode(1'b0, 1'b0));
        memReady = 1'b0;
        step("sw-exec", sExec(ALU_ADD, 1'b1, 2'b00, 1'b0));
        step("sw-mem-wait", sMem(1'b1, 1'b0, 1'b1));
        rst_n = 1'b0;
        stepNow("sw-reset-async", sInit());
        @(posedge clk);
        #1;
        step("sw-reset-hold", sInit());
        rst_n = 1'b1;
        step("sw-release-init", sInit());
        step("sw-release-fetch", sFetch(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
